pdu_pchlist_builder: RTL and testbench

Parametrised, sequential successor to the patch-list decoder in the PDU. It accepts a stream of logical-qubit requests, each naming a logical qubit and up to `NUM_RD` patch indices. It accumulates the qubit's Pauli product, opcode and measurement register into registered per-patch lists across a batch. When the batch closes it presents the complete per-patch lists downstream through a valid/ready handshake.

---
 rtl/pdu_pkg.sv | 22 ++
 rtl/pdu_pchlist_builder_if.sv | 49 ++++
 rtl/pdu_pch_slot.sv | 57 +++++
 rtl/pdu_pchlist_builder.sv | 138 +++++++++++++
 tb/tb_pdu_pchlist_builder.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pdu_pkg.sv
`default_nettype none
// ============================================================================
//  pdu_pkg
//  Shared defaults and types for the PDU patch-list builder.
//  Revision: 1.0  initial release
// ============================================================================
package pdu_pkg;

    localparam int NUM_PCH   = 16;
    localparam int NUM_LQ    = 8;
    localparam int OPCODE_BW = 4;

    // Opcode carried by any patch slot that holds no request.
    localparam logic [OPCODE_BW-1:0] INVALID_OPCODE = 4'hF;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } pdu_state_e;

endpackage : pdu_pkg
`default_nettype wire

// File: rtl/pdu_pchlist_builder_if.sv
`default_nettype none
// ============================================================================
//  pdu_pchlist_builder_if
//  Request stream, LQ list inputs and per-patch batch outputs of the builder.
//  Revision: 1.0  initial release
// ============================================================================
interface pdu_pchlist_builder_if #(
    parameter int NUM_PCH   = pdu_pkg::NUM_PCH,
    parameter int NUM_LQ    = pdu_pkg::NUM_LQ,
    parameter int NUM_RD    = 2,
    parameter int OPCODE_BW = pdu_pkg::OPCODE_BW
);
    localparam int PCHADDR_BW = $clog2(NUM_PCH);
    localparam int LQADDR_BW  = $clog2(NUM_LQ);

    logic                            in_valid;
    logic                            in_ready;
    logic                            in_last;
    logic [LQADDR_BW-1:0]            in_lqidx;
    logic [NUM_RD-1:0]               in_rd_en;
    logic [NUM_RD*PCHADDR_BW-1:0]    in_rd_pchidx;
    logic [NUM_LQ*2-1:0]             lpplist_reg;
    logic [NUM_LQ*OPCODE_BW-1:0]     oplist_reg;
    logic [NUM_LQ*LQADDR_BW-1:0]     mreglist_reg;
    logic                            out_valid;
    logic                            out_ready;
    logic [NUM_PCH-1:0]              pch_list;
    logic [NUM_PCH*2-1:0]            pchpp_list;
    logic [NUM_PCH*OPCODE_BW-1:0]    pchop_list;
    logic [NUM_PCH*LQADDR_BW-1:0]    pchmreg_list;
    logic                            out_conflict;
    logic                            out_err;

    modport master (
        output in_valid, in_last, in_lqidx, in_rd_en, in_rd_pchidx,
               lpplist_reg, oplist_reg, mreglist_reg, out_ready,
        input  in_ready, out_valid, pch_list, pchpp_list, pchop_list,
               pchmreg_list, out_conflict, out_err
    );

    modport slave (
        input  in_valid, in_last, in_lqidx, in_rd_en, in_rd_pchidx,
               lpplist_reg, oplist_reg, mreglist_reg, out_ready,
        output in_ready, out_valid, pch_list, pchpp_list, pchop_list,
               pchmreg_list, out_conflict, out_err
    );

endinterface : pdu_pchlist_builder_if
`default_nettype wire

// File: rtl/pdu_pch_slot.sv
`default_nettype none
// ============================================================================
//  pdu_pch_slot
//  One patch entry: used bit, Pauli product, opcode and measurement register.
//  Revision: 1.0  initial release
// ============================================================================
module pdu_pch_slot
    import pdu_pkg::*;
#(
    parameter int OPCODE_BW = pdu_pkg::OPCODE_BW,
    parameter int LQADDR_BW = 3
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_we,
    input  wire logic                 i_clr,
    input  wire logic [1:0]           i_pp,
    input  wire logic [OPCODE_BW-1:0] i_op,
    input  wire logic [LQADDR_BW-1:0] i_mreg,
    output logic                      o_bit,
    output logic [1:0]                o_pp,
    output logic [OPCODE_BW-1:0]      o_op,
    output logic [LQADDR_BW-1:0]      o_mreg
);
    localparam logic [OPCODE_BW-1:0] c_invalid_op = OPCODE_BW'(INVALID_OPCODE);

    logic                 r_bit;
    logic [1:0]           r_pp;
    logic [OPCODE_BW-1:0] r_op;
    logic [LQADDR_BW-1:0] r_mreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit  <= 1'b0;
            r_pp   <= '0;
            r_op   <= c_invalid_op;
            r_mreg <= '0;
        end else if (i_clr) begin
            r_bit  <= 1'b0;
            r_pp   <= '0;
            r_op   <= c_invalid_op;
            r_mreg <= '0;
        end else if (i_we) begin
            r_bit  <= 1'b1;
            r_pp   <= i_pp;
            r_op   <= i_op;
            r_mreg <= i_mreg;
        end
    end

    assign o_bit  = r_bit;
    assign o_pp   = r_pp;
    assign o_op   = r_op;
    assign o_mreg = r_mreg;

endmodule : pdu_pch_slot
`default_nettype wire

// File: rtl/pdu_pchlist_builder.sv
`default_nettype none
// ============================================================================
//  pdu_pchlist_builder
//  Accumulates per-patch lists over a batch of LQ requests, then hands the
//  batch downstream. Build option: PDU_CONFLICT_CHK_EN (first writer wins).
//  Revision: 1.0  initial release
// ============================================================================
module pdu_pchlist_builder
    import pdu_pkg::*;
#(
    parameter int NUM_PCH   = pdu_pkg::NUM_PCH,
    parameter int NUM_LQ    = pdu_pkg::NUM_LQ,
    parameter int NUM_RD    = 2,
    parameter int OPCODE_BW = pdu_pkg::OPCODE_BW
) (
    input  wire logic             clk,
    input  wire logic             rst,
    pdu_pchlist_builder_if.slave  bus
);
    localparam int PCHADDR_BW = $clog2(NUM_PCH);
    localparam int LQADDR_BW  = $clog2(NUM_LQ);

    pdu_state_e                   r_state;
    logic                         r_err;
    logic                         w_in_ready;
    logic                         w_accept;
    logic                         w_consume;
    logic                         w_lq_ok;
    logic [LQADDR_BW-1:0]         w_lq_sel;
    logic [1:0]                   w_pp;
    logic [OPCODE_BW-1:0]         w_op;
    logic [LQADDR_BW-1:0]         w_mreg;
    logic [NUM_PCH-1:0]           w_hit;
    logic [NUM_PCH-1:0]           w_we;
    logic [NUM_PCH-1:0]           w_pch_list;
    logic [NUM_PCH*2-1:0]         w_pchpp_list;
    logic [NUM_PCH*OPCODE_BW-1:0] w_pchop_list;
    logic [NUM_PCH*LQADDR_BW-1:0] w_pchmreg_list;

    assign w_in_ready = (r_state == ACCUM) & ~rst;
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_consume  = (r_state == OUT) & bus.out_ready;

    // Out-of-range LQ indices fall back to entry 0 so the mux never reads past the lists.
    assign w_lq_ok  = int'(bus.in_lqidx) < NUM_LQ;
    assign w_lq_sel = w_lq_ok ? bus.in_lqidx : '0;
    assign w_pp     = bus.lpplist_reg[2*w_lq_sel +: 2];
    assign w_op     = bus.oplist_reg[OPCODE_BW*w_lq_sel +: OPCODE_BW];
    assign w_mreg   = bus.mreglist_reg[LQADDR_BW*w_lq_sel +: LQADDR_BW];

    always_comb begin
        w_hit = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (w_accept && w_lq_ok && bus.in_rd_en[k] &&
                int'(bus.in_rd_pchidx[k*PCHADDR_BW +: PCHADDR_BW]) < NUM_PCH) begin
                w_hit[bus.in_rd_pchidx[k*PCHADDR_BW +: PCHADDR_BW]] = 1'b1;
            end
        end
    end

`ifdef PDU_CONFLICT_CHK_EN
    // A slot already set in this batch belongs to an earlier request and is kept.
    logic r_conflict;
    logic w_conflict;
    assign w_we       = w_hit & ~w_pch_list;
    assign w_conflict = |(w_hit & w_pch_list);
    assign bus.out_conflict = r_conflict;
`else
    assign w_we = w_hit;
    assign bus.out_conflict = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCUM;
            r_err   <= 1'b0;
`ifdef PDU_CONFLICT_CHK_EN
            r_conflict <= 1'b0;
`endif
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        if (!w_lq_ok)
                            r_err <= 1'b1;
`ifdef PDU_CONFLICT_CHK_EN
                        if (w_conflict)
                            r_conflict <= 1'b1;
`endif
                        if (bus.in_last)
                            r_state <= OUT;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        r_state <= ACCUM;
                        r_err   <= 1'b0;
`ifdef PDU_CONFLICT_CHK_EN
                        r_conflict <= 1'b0;
`endif
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    generate
        for (genvar p = 0; p < NUM_PCH; p++) begin : g_slot
            pdu_pch_slot #(
                .OPCODE_BW (OPCODE_BW),
                .LQADDR_BW (LQADDR_BW)
            ) u_slot (
                .clk    (clk),
                .rst    (rst),
                .i_we   (w_we[p]),
                .i_clr  (w_consume),
                .i_pp   (w_pp),
                .i_op   (w_op),
                .i_mreg (w_mreg),
                .o_bit  (w_pch_list[p]),
                .o_pp   (w_pchpp_list[2*p +: 2]),
                .o_op   (w_pchop_list[OPCODE_BW*p +: OPCODE_BW]),
                .o_mreg (w_pchmreg_list[LQADDR_BW*p +: LQADDR_BW])
            );
        end
    endgenerate

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = (r_state == OUT);
    assign bus.out_err      = r_err;
    assign bus.pch_list     = w_pch_list;
    assign bus.pchpp_list   = w_pchpp_list;
    assign bus.pchop_list   = w_pchop_list;
    assign bus.pchmreg_list = w_pchmreg_list;

endmodule : pdu_pchlist_builder
`default_nettype wire

// File: tb/tb_pdu_pchlist_builder.sv
`default_nettype none
// ============================================================================
//  tb_pdu_pchlist_builder
//  Directed and random requests against an array-based batch model.
//  Non-power-of-two NUM_PCH/NUM_LQ so out-of-range indices are expressible.
//  Revision: 1.0  initial release
// ============================================================================
module tb_pdu_pchlist_builder;
    import pdu_pkg::*;

    localparam int NUM_PCH    = 12;
    localparam int NUM_LQ     = 6;
    localparam int NUM_RD     = 2;
    localparam int OPCODE_BW  = 4;
    localparam int PCHADDR_BW = 4;
    localparam int LQADDR_BW  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pdu_pchlist_builder_if #(
        .NUM_PCH(NUM_PCH), .NUM_LQ(NUM_LQ), .NUM_RD(NUM_RD), .OPCODE_BW(OPCODE_BW)
    ) bus ();

    pdu_pchlist_builder #(
        .NUM_PCH(NUM_PCH), .NUM_LQ(NUM_LQ), .NUM_RD(NUM_RD), .OPCODE_BW(OPCODE_BW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference batch state
    logic                 m_bit  [NUM_PCH];
    logic [1:0]           m_pp   [NUM_PCH];
    logic [OPCODE_BW-1:0] m_op   [NUM_PCH];
    logic [LQADDR_BW-1:0] m_mreg [NUM_PCH];
    logic                 m_out, m_conf, m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NUM_PCH; p++) begin
            m_bit[p]  = 1'b0;
            m_pp[p]   = '0;
            m_op[p]   = INVALID_OPCODE;
            m_mreg[p] = '0;
        end
        m_out  = 1'b0;
        m_conf = 1'b0;
        m_err  = 1'b0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        logic prior [NUM_PCH];
        int   lq, idx;
        if (!m_out) begin
            if (bus.in_valid) begin
                prior = m_bit;
                lq = int'(bus.in_lqidx);
                if (lq >= NUM_LQ) begin
                    m_err = 1'b1;
                end else begin
                    for (int k = 0; k < NUM_RD; k++) begin
                        idx = int'(bus.in_rd_pchidx[k*PCHADDR_BW +: PCHADDR_BW]);
                        if (bus.in_rd_en[k] && idx < NUM_PCH) begin
`ifdef PDU_CONFLICT_CHK_EN
                            if (prior[idx]) begin
                                m_conf = 1'b1;
                                continue;
                            end
`endif
                            m_bit[idx]  = 1'b1;
                            m_pp[idx]   = bus.lpplist_reg[2*lq +: 2];
                            m_op[idx]   = bus.oplist_reg[OPCODE_BW*lq +: OPCODE_BW];
                            m_mreg[idx] = bus.mreglist_reg[LQADDR_BW*lq +: LQADDR_BW];
                        end
                    end
                end
                if (bus.in_last)
                    m_out = 1'b1;
            end
        end else if (bus.out_ready) begin
            model_reset();
        end
    endtask

    task automatic check_all(input string tag);
        logic [NUM_PCH-1:0]           e_bit;
        logic [NUM_PCH*2-1:0]         e_pp;
        logic [NUM_PCH*OPCODE_BW-1:0] e_op;
        logic [NUM_PCH*LQADDR_BW-1:0] e_mreg;
        for (int p = 0; p < NUM_PCH; p++) begin
            e_bit[p]                         = m_bit[p];
            e_pp[2*p +: 2]                   = m_pp[p];
            e_op[OPCODE_BW*p +: OPCODE_BW]   = m_op[p];
            e_mreg[LQADDR_BW*p +: LQADDR_BW] = m_mreg[p];
        end
        chk({tag, ".pch"},  64'(bus.pch_list),     64'(e_bit));
        chk({tag, ".pp"},   64'(bus.pchpp_list),   64'(e_pp));
        chk({tag, ".op"},   64'(bus.pchop_list),   64'(e_op));
        chk({tag, ".mreg"}, 64'(bus.pchmreg_list), 64'(e_mreg));
        chk({tag, ".ordy"}, 64'(bus.in_ready),     64'(!m_out && !rst));
        chk({tag, ".oval"}, 64'(bus.out_valid),    64'(m_out));
        chk({tag, ".conf"}, 64'(bus.out_conflict), 64'(m_conf));
        chk({tag, ".err"},  64'(bus.out_err),      64'(m_err));
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_lq(input int lq, input logic [1:0] pp,
                          input logic [OPCODE_BW-1:0] op, input logic [LQADDR_BW-1:0] mreg);
        bus.lpplist_reg[2*lq +: 2]                  = pp;
        bus.oplist_reg[OPCODE_BW*lq +: OPCODE_BW]   = op;
        bus.mreglist_reg[LQADDR_BW*lq +: LQADDR_BW] = mreg;
    endtask

    task automatic drive(input logic v, input logic last, input int lq, input logic [1:0] en,
                         input int idx0, input int idx1, input logic ordy);
        bus.in_valid     = v;
        bus.in_last      = last;
        bus.in_lqidx     = LQADDR_BW'(lq);
        bus.in_rd_en     = en;
        bus.in_rd_pchidx = {PCHADDR_BW'(idx1), PCHADDR_BW'(idx0)};
        bus.out_ready    = ordy;
    endtask

    task automatic randomize_lists();
        bus.lpplist_reg  = (NUM_LQ*2)'({$urandom, $urandom});
        bus.oplist_reg   = (NUM_LQ*OPCODE_BW)'({$urandom, $urandom});
        bus.mreglist_reg = (NUM_LQ*LQADDR_BW)'({$urandom, $urandom});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(1'b0, 1'b0, 0, 2'b00, 0, 0, 1'b0);
        randomize_lists();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;
        #1;
        check_all("post_reset");

        // Single request: lq3 claims patches 4 and 9, consumed immediately
        set_lq(3, 2'b01, 4'd5, 3'd6);
        drive(1'b1, 1'b1, 3, 2'b11, 4, 9, 1'b1);
        cycle("single");
        chk("single_pch_const", 64'(bus.pch_list), 64'h210);
        chk("single_op4_const", 64'(bus.pchop_list[4*OPCODE_BW +: OPCODE_BW]), 64'd5);
        drive(1'b0, 1'b0, 0, 2'b00, 0, 0, 1'b1);
        cycle("single_clr");
        chk("single_clr_pch", 64'(bus.pch_list), 64'h0);

        // Two-request batch held for five cycles with requests still offered
        set_lq(0, 2'b10, 4'd3, 3'd1);
        set_lq(1, 2'b11, 4'd7, 3'd2);
        drive(1'b1, 1'b0, 0, 2'b01, 1, 0, 1'b0);
        cycle("two_a");
        drive(1'b1, 1'b1, 1, 2'b01, 2, 0, 1'b0);
        cycle("two_b");
        repeat (5) begin
            drive(1'b1, 1'b1, 2, 2'b11, 3, 5, 1'b0);
            cycle("two_hold");
        end
        drive(1'b0, 1'b0, 0, 2'b00, 0, 0, 1'b1);
        cycle("two_consume");

        // Conflict on patch 7
        set_lq(0, 2'b01, 4'd1, 3'd3);
        set_lq(1, 2'b10, 4'd2, 3'd4);
        drive(1'b1, 1'b0, 0, 2'b01, 7, 0, 1'b0);
        cycle("conf_a");
        drive(1'b1, 1'b1, 1, 2'b10, 0, 7, 1'b0);
        cycle("conf_b");
`ifdef PDU_CONFLICT_CHK_EN
        chk("conf_op7_const", 64'(bus.pchop_list[7*OPCODE_BW +: OPCODE_BW]), 64'd1);
        chk("conf_flag_const", 64'(bus.out_conflict), 64'd1);
`else
        chk("conf_op7_const", 64'(bus.pchop_list[7*OPCODE_BW +: OPCODE_BW]), 64'd2);
        chk("conf_flag_const", 64'(bus.out_conflict), 64'd0);
`endif
        drive(1'b0, 1'b0, 0, 2'b00, 0, 0, 1'b1);
        cycle("conf_consume");

        // Bad LQ index closes the batch with only the error flag
        drive(1'b1, 1'b1, NUM_LQ, 2'b11, 2, 3, 1'b0);
        cycle("bad_lq");
        chk("bad_lq_err_const", 64'(bus.out_err), 64'd1);
        chk("bad_lq_pch_const", 64'(bus.pch_list), 64'h0);
        drive(1'b0, 1'b0, 0, 2'b00, 0, 0, 1'b1);
        cycle("bad_lq_consume");

        // Out-of-range patch lane is dropped silently
        drive(1'b1, 1'b1, 2, 2'b11, 14, 5, 1'b0);
        cycle("bad_pch");
        chk("bad_pch_pch_const", 64'(bus.pch_list), 64'h020);
        chk("bad_pch_err_const", 64'(bus.out_err), 64'd0);
        drive(1'b0, 1'b0, 0, 2'b00, 0, 0, 1'b1);
        cycle("bad_pch_consume");

        // Asynchronous reset while presenting a batch
        drive(1'b1, 1'b1, 4, 2'b11, 0, 11, 1'b0);
        cycle("pre_rst");
        drive(1'b0, 1'b0, 0, 2'b00, 0, 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_in_out");
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_all("rst_release");

        // Empty batch
        drive(1'b1, 1'b1, 1, 2'b00, 3, 4, 1'b0);
        cycle("empty");
        chk("empty_oval_const", 64'(bus.out_valid), 64'd1);
        drive(1'b0, 1'b0, 0, 2'b00, 0, 0, 1'b1);
        cycle("empty_consume");

        // Random traffic
        repeat (400) begin
            randomize_lists();
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 6)), 2'($urandom),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)));
            cycle("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pdu_pchlist_builder
`default_nettype wire
